// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controllers: opcodes, the sequencer
// state encoding and the constant beat value returned on an error.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] ERR_BEAT = 8'hFF;

  // 4-bit encoding keeps this controller aligned with its siblings
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LD_Y   = 4'd1,
    ST_EXEC   = 4'd2,
    ST_WAIT   = 4'd3,
    ST_OUT_HI = 4'd4,
    ST_OUT_LO = 4'd5
  } seq_state_t;

  // True when the operation has to be handed to an iterative unit;
  // a divide by zero is resolved locally as an error instead.
  function automatic logic uses_unit(input logic [1:0] op, input logic [7:0] y);
    return (op == OP_MUL) || ((op == OP_DIV) && (y != 8'h00));
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Watchdog counter for the sequencer WAIT state. It counts enabled
// cycles since the last clear; expired flags that the current count is
// TIMEOUT-1, i.e. the cycle in progress is the TIMEOUT-th one waited.
module seq_timeout_cnt #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Clear has priority so a new unit launch always starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Operation sequencer for the 8-bit ALU: collects opcode and operands
// from inbus, does add/sub locally, launches mul/div on the iterative
// units, guards them with a watchdog and returns two result beats.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] inbus,
  output logic       ready,
  output logic       out_valid,
  output logic [7:0] outbus,
  output logic       done,
  output logic       err,
  output logic       unit_sel,
  output logic       unit_start,
  output logic [7:0] unit_q,
  output logic [7:0] unit_m,
  input  logic       unit_done,
  input  logic [7:0] a_res,
  input  logic [7:0] q_res
);

  seq_state_t state, state_next;

  logic [1:0] op_reg;
  logic [7:0] x_reg;
  logic [7:0] y_reg;
  logic [7:0] hi_reg;
  logic [7:0] lo_reg;
  logic       err_flag;
  logic [8:0] sum9;
  logic [7:0] diff;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  assign sum9 = {1'b0, x_reg} + {1'b0, y_reg};
  assign diff = x_reg - y_reg;

  // Watchdog restarts when a unit is launched and only advances while
  // the unit has not yet answered
  assign wd_clr = (state == ST_EXEC);
  assign wd_en  = (state == ST_WAIT) && !unit_done;

  seq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and outputs driven from state and registers only
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    out_valid  = 1'b0;
    outbus     = 8'h00;
    done       = 1'b0;
    err        = 1'b0;
    unit_start = 1'b0;
    unit_sel   = (op_reg == OP_DIV);
    unit_q     = x_reg;
    unit_m     = y_reg;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = ST_LD_Y;
      end
      ST_LD_Y: state_next = ST_EXEC;
      ST_EXEC: begin
        if (uses_unit(op_reg, y_reg)) begin
          unit_start = 1'b1;
          state_next = ST_WAIT;
        end else begin
          state_next = ST_OUT_HI;
        end
      end
      ST_WAIT: begin
        if (unit_done || wd_expired) state_next = ST_OUT_HI;
      end
      ST_OUT_HI: begin
        out_valid  = 1'b1;
        outbus     = hi_reg;
        state_next = ST_OUT_LO;
      end
      ST_OUT_LO: begin
        out_valid  = 1'b1;
        outbus     = lo_reg;
        done       = 1'b1;
        err        = err_flag;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, local arithmetic and result/error bookkeeping;
  // unit_done is given priority over a watchdog expiry in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg   <= OP_ADD;
      x_reg    <= 8'h00;
      y_reg    <= 8'h00;
      hi_reg   <= 8'h00;
      lo_reg   <= 8'h00;
      err_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_reg <= op;
            x_reg  <= inbus;
          end
        end
        ST_LD_Y: y_reg <= inbus;
        ST_EXEC: begin
          case (op_reg)
            OP_ADD: begin
              hi_reg <= {7'b0, sum9[8]};
              lo_reg <= sum9[7:0];
            end
            OP_SUB: begin
              hi_reg <= {7'b0, (x_reg < y_reg)};
              lo_reg <= diff;
            end
            OP_DIV: begin
              if (y_reg == 8'h00) begin
                hi_reg   <= ERR_BEAT;
                lo_reg   <= ERR_BEAT;
                err_flag <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_WAIT: begin
          if (unit_done) begin
            hi_reg <= a_res;
            lo_reg <= q_res;
          end else if (wd_expired) begin
            hi_reg   <= ERR_BEAT;
            lo_reg   <= ERR_BEAT;
            err_flag <= 1'b1;
          end
        end
        ST_OUT_LO: err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Top-level operation sequencer for the 8-bit ALU. It accepts an opcode and two operands over the shared 8-bit `inbus`. It performs add/sub itself and dispatches mul/div to the iterative multiply/divide datapaths through a start/done handshake. Results are returned as two beats on `outbus`. A watchdog aborts an iterative unit that never reports completion.

## Interface
- `TIMEOUT`, default 32: maximum cycles spent in WAIT before abort; range 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; honoured only in IDLE.
- `op` in 2: sampled with `start`. 00 add, 01 sub, 10 mul, 11 div.
- `inbus` in 8: operand X in the `start` cycle, operand Y in the following cycle.
- `ready` out 1: high only in IDLE.
- `out_valid` out 1: `outbus` carries a result beat.
- `outbus` out 8: result beat; 8'h00 whenever `out_valid` is 0.
- `done` out 1: one-cycle pulse on the last result beat.
- `err` out 1: one-cycle pulse, coincident with `done`, for divide-by-zero or timeout.
- `unit_sel` out 1: 0 multiplier, 1 divider.
- `unit_start` out 1: one-cycle pulse that launches the selected unit.
- `unit_q` out 8: operand X (multiplier / dividend); held stable from EXEC until WAIT exits.
- `unit_m` out 8: operand Y (multiplicand / divisor); held stable over the same window.
- `unit_done` in 1: completion from the selected unit; sampled only in WAIT.
- `a_res` in 8: unit high result (product high / remainder); captured when `unit_done` is sampled.
- `q_res` in 8: unit low result (product low / quotient); captured with `a_res`.

## Operation
- States: IDLE → LD_Y → EXEC → (WAIT) → OUT_HI → OUT_LO → IDLE.
- **IDLE:** on `start`, latch `op` and latch `inbus` into X, then go to LD_Y.
- **LD_Y:** latch `inbus` into Y, then go to EXEC.
- **EXEC, add:** compute 9-bit X+Y. hi = {7'b0, carry}, lo = sum[7:0]. Go to OUT_HI.
- **EXEC, sub:** compute X−Y. hi = {7'b0, borrow}, where borrow = (X < Y) unsigned; lo = difference[7:0]. Go to OUT_HI.
- **EXEC, mul:** pulse `unit_start` with `unit_sel`=0, clear the watchdog, go to WAIT.
- **EXEC, div with Y ≠ 0:** pulse `unit_start` with `unit_sel`=1, clear the watchdog, go to WAIT.
- **EXEC, div with Y == 0:** no `unit_start`. Set hi = lo = 8'hFF, set the error flag, go to OUT_HI.
- **WAIT:** each cycle, if `unit_done` is high, capture `a_res`/`q_res` as hi/lo and go to OUT_HI. Otherwise increment the watchdog. When it reaches TIMEOUT, set hi = lo = 8'hFF, set the error flag, and go to OUT_HI.
- **OUT_HI:** `out_valid`=1, `outbus`=hi.
- **OUT_LO:** `out_valid`=1, `outbus`=lo, `done`=1, `err`=error flag. Go to IDLE and clear the error flag.
- `start` outside IDLE is ignored; it is neither queued nor does it perturb the current operation.
- `unit_done` outside WAIT is ignored.
- If `unit_done` arrives in the cycle the watchdog reaches TIMEOUT, `unit_done` wins and no error is raised.

## Timing
- Reset values: state IDLE; `ready` 1; `out_valid`, `done`, `err`, `unit_start`, `unit_sel` 0; `outbus`, `unit_q`, `unit_m` 8'h00; watchdog and error flag 0.
- Reset mid-operation returns to IDLE immediately. Any in-flight unit result is discarded, and no `done` is produced for the aborted operation.
- Add/sub and div-by-zero: `start` at T0, Y sampled at T1, EXEC at T2, OUT_HI at T3, OUT_LO with `done` at T4. `ready` returns at T5.
- Mul/div: `unit_start` at T2, WAIT from T3. If `unit_done` is sampled at Tn, OUT_HI is at Tn+1 and OUT_LO is at Tn+2.
- Timeout: the abort fires on the TIMEOUT-th WAIT cycle without `unit_done`. The error beats follow on the next two cycles.
- All outputs are registered or decoded from state only; there is no combinational path from `start`, `inbus`, or `unit_done` to any output.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`
  - state encoding (4-bit, matching the 4-bit state convention of the other ALU controllers)
  - `ERR_BEAT` = 8'hFF
- Sub-module `seq_timeout_cnt`: clearable, enabled up-counter of width $clog2(TIMEOUT+1), with an `expired` output. Its reset is asynchronous, active-high, on `rst`.

## Test plan
- **Add:** X=8'hF0, Y=8'h20 → beats 8'h01, 8'h10; `done` on the second beat; `err`=0; `unit_start` never asserted.
- **Sub:** X=8'h05, Y=8'h07 → beats 8'h01, 8'hFE; `done` at T4.
- **Mul:** X=12, Y=13; the unit model raises `unit_done` with a_res=8'h00, q_res=8'h9C nine cycles after `unit_start` → exactly one `unit_start` with `unit_sel`=0; `unit_q`/`unit_m` stable at 12/13 throughout WAIT; beats 8'h00, 8'h9C.
- **Div by zero:** X=100, Y=0 → no `unit_start`; beats 8'hFF, 8'hFF; `done`=`err`=1 at T4.
- **Timeout and done/timeout collision (TIMEOUT=32):** a div unit that never raises done → error beats after 32 WAIT cycles with `err`=1. Repeat with `unit_done` on exactly the 32nd WAIT cycle → normal result with `err`=0.
- **Robustness:** `start` pulsed during WAIT is ignored (no second `unit_start`, no extra `done`). `rst` asserted mid-WAIT → next cycle `ready`=1, `out_valid`=0, and a subsequent add completes normally.
